// File: rtl/vc_vr_multi_converter.sv
// Multi-VC valid/credit to valid/ready converter: per-VC FIFOs, per-VC credit
// return and a stall-safe round-robin merge onto a single valid/ready output.
module vc_vr_multi_converter #(
   parameter int unsigned  DATA_WIDTH = 8,
   parameter int unsigned  CREDIT_NUM = 2,
   parameter int unsigned  VC_NUM     = 2,
   localparam int unsigned VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic [VC_W-1:0]       s_vc_i,
   input  logic                  s_valid_i,
   output logic [VC_NUM-1:0]     s_credit_o,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic [VC_W-1:0]       m_vc_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  err_o
);

   localparam int unsigned PTR_W = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;
   localparam int unsigned CNT_W = $clog2(CREDIT_NUM + 1);

   typedef enum logic {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   arb_state_e              state, state_nxt;
   logic [VC_W-1:0]         lock_vc, lock_vc_nxt;
   logic [VC_W-1:0]         rr_ptr, rr_ptr_nxt;
   logic [VC_W-1:0]         grant, grant_free;
   logic [VC_W:0]           idx;
   logic                    any_req;
   logic                    handshake;
   logic                    legal_vc;
   logic                    drop;
   logic [VC_NUM-1:0]       push, pop, full, empty;
   logic [DATA_WIDTH-1:0]   head [VC_NUM];

   assign legal_vc = ({1'b0, s_vc_i} < (VC_W+1)'(VC_NUM));
   assign drop     = s_valid_i && !(|push);

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      logic [DATA_WIDTH-1:0] mem [CREDIT_NUM];
      logic [PTR_W-1:0]      wr_ptr, rd_ptr;
      logic [CNT_W-1:0]      cnt, pend;
      logic [CNT_W:0]        avail;
      logic                  credit_q;

      assign push[v]       = s_valid_i && legal_vc && (s_vc_i == VC_W'(v)) && !full[v];
      assign pop[v]        = handshake && (grant == VC_W'(v));
      assign full[v]       = (cnt == CNT_W'(CREDIT_NUM));
      assign empty[v]      = (cnt == '0);
      assign head[v]       = mem[rd_ptr];
      assign avail         = {1'b0, pend} + (CNT_W+1)'(pop[v]);
      assign s_credit_o[v] = credit_q;

      // Flit storage; contents are don't-care until written.
      always_ff @(posedge clk) begin
         if (push[v]) mem[wr_ptr] <= s_data_i;
      end

      // FIFO pointers and occupancy; a full FIFO never accepts, even on a same-cycle pop.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push[v]) wr_ptr <= (wr_ptr == PTR_W'(CREDIT_NUM - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop[v])  rd_ptr <= (rd_ptr == PTR_W'(CREDIT_NUM - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push[v] && !pop[v])      cnt <= cnt + CNT_W'(1);
            else if (pop[v] && !push[v]) cnt <= cnt - CNT_W'(1);
         end
      end

      // Owed-credit counter: releases at most one credit per cycle, reset owes the full depth.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend     <= CNT_W'(CREDIT_NUM);
            credit_q <= 1'b0;
         end else if (avail != '0) begin
            pend     <= CNT_W'(avail - (CNT_W+1)'(1));
            credit_q <= 1'b1;
         end else begin
            pend     <= '0;
            credit_q <= 1'b0;
         end
      end
   end

   // Round-robin scan: first non-empty VC starting at rr_ptr, wrapping past VC_NUM-1.
   always_comb begin
      grant_free = '0;
      any_req    = 1'b0;
      idx        = '0;
      for (int i = 0; i < int'(VC_NUM); i++) begin
         idx = {1'b0, rr_ptr} + (VC_W+1)'(i);
         if (idx >= (VC_W+1)'(VC_NUM)) idx = idx - (VC_W+1)'(VC_NUM);
         if (!any_req && !empty[idx[VC_W-1:0]]) begin
            any_req    = 1'b1;
            grant_free = idx[VC_W-1:0];
         end
      end
   end

   // Arbiter next state: lock the grant while the consumer stalls so the output stays stable.
   always_comb begin
      state_nxt   = state;
      lock_vc_nxt = lock_vc;
      rr_ptr_nxt  = rr_ptr;
      grant       = grant_free;
      m_valid_o   = any_req;
      if (state == ST_LOCKED) begin
         grant     = lock_vc;
         m_valid_o = !empty[lock_vc];
      end
      handshake = m_valid_o && m_ready_i;
      case (state)
         ST_FREE: begin
            if (m_valid_o && !m_ready_i) begin
               state_nxt   = ST_LOCKED;
               lock_vc_nxt = grant;
            end
         end
         ST_LOCKED: begin
            if (m_ready_i) state_nxt = ST_FREE;
         end
         default: state_nxt = ST_FREE;
      endcase
      if (handshake) rr_ptr_nxt = (grant == VC_W'(VC_NUM - 1)) ? '0 : grant + VC_W'(1);
   end

   // Output payload follows the granted FIFO head.
   always_comb begin
      m_data_o = '0;
      m_vc_o   = grant;
      for (int v = 0; v < int'(VC_NUM); v++) begin
         if (grant == VC_W'(v)) m_data_o = head[v];
      end
   end

   // Arbiter state, round-robin pointer and sticky protocol error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_FREE;
         lock_vc <= '0;
         rr_ptr  <= '0;
         err_o   <= 1'b0;
      end else begin
         state   <= state_nxt;
         lock_vc <= lock_vc_nxt;
         rr_ptr  <= rr_ptr_nxt;
         if (drop) err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vc_vr_multi_converter.sv
// Bench for vc_vr_multi_converter: directed scenarios plus a randomized run
// against a queue-based model (4 VCs), and a 5-VC instance for illegal VC ids.
module tb_vc_vr_multi_converter;

   localparam int unsigned DW  = 8;
   localparam int unsigned CN  = 2;
   localparam int unsigned VN  = 4;
   localparam int unsigned VW  = 2;
   localparam int unsigned VN2 = 5;
   localparam int unsigned VW2 = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] s_data;
   logic [VW-1:0] s_vc;
   logic          s_valid;
   logic [VN-1:0] s_credit;
   logic [DW-1:0] m_data;
   logic [VW-1:0] m_vc;
   logic          m_valid;
   logic          m_ready;
   logic          err;

   logic [DW-1:0]  d2_s_data;
   logic [VW2-1:0] d2_s_vc;
   logic           d2_s_valid;
   logic [VN2-1:0] d2_s_credit;
   logic [DW-1:0]  d2_m_data;
   logic [VW2-1:0] d2_m_vc;
   logic           d2_m_valid;
   logic           d2_m_ready;
   logic           d2_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vc_vr_multi_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN), .VC_NUM(VN)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(s_data), .s_vc_i(s_vc), .s_valid_i(s_valid), .s_credit_o(s_credit),
      .m_data_o(m_data), .m_vc_o(m_vc), .m_valid_o(m_valid), .m_ready_i(m_ready),
      .err_o(err)
   );

   vc_vr_multi_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN), .VC_NUM(VN2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(d2_s_data), .s_vc_i(d2_s_vc), .s_valid_i(d2_s_valid), .s_credit_o(d2_s_credit),
      .m_data_o(d2_m_data), .m_vc_o(d2_m_vc), .m_valid_o(d2_m_valid), .m_ready_i(d2_m_ready),
      .err_o(d2_err)
   );

   // Reference model of the 4-VC instance: one queue per VC, owed credits per VC,
   // round-robin pointer and an optional locked VC.
   logic [DW-1:0] mq [VN][$];
   int            mpend [VN];
   logic [VN-1:0] mcred;
   logic          merr;
   int            mrr;
   bit            mlocked;
   int            mlock_vc;

   function automatic int exp_grant();
      if (mlocked) return mlock_vc;
      for (int i = 0; i < VN; i++) begin
         int v;
         v = (mrr + i) % VN;
         if (mq[v].size() > 0) return v;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < VN; v++) begin
         mq[v].delete();
         mpend[v] = CN;
      end
      mcred = '0; merr = 1'b0; mrr = 0; mlocked = 1'b0; mlock_vc = 0;
   endfunction

   function automatic void model_edge(bit valid, int vc, logic [DW-1:0] d, bit rdy);
      int g;
      bit hs;
      bit accept;
      int owed;
      g      = exp_grant();
      hs     = (g >= 0) && rdy;
      accept = 1'b0;
      if (valid) begin
         if (vc < VN) begin
            if (mq[vc].size() < CN) accept = 1'b1;
         end
         if (!accept) merr = 1'b1;
      end
      if (hs) void'(mq[g].pop_front());
      if (accept) mq[vc].push_back(d);
      for (int v = 0; v < VN; v++) begin
         owed = mpend[v] + ((hs && g == v) ? 1 : 0);
         mcred[v] = (owed > 0);
         mpend[v] = (owed > 0) ? owed - 1 : 0;
      end
      if (hs) begin
         mrr = (g + 1) % VN;
         mlocked = 1'b0;
      end else if (g >= 0 && !mlocked) begin
         mlocked = 1'b1;
         mlock_vc = g;
      end
   endfunction

   // One clock: drive inputs, advance model on the edge, return at the next falling edge.
   task automatic cycle(input bit valid, input int vc, input logic [DW-1:0] d, input bit rdy);
      s_valid = valid;
      s_vc    = VW'(vc);
      s_data  = d;
      m_ready = rdy;
      @(posedge clk);
      model_edge(valid, vc, d, rdy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      s_valid = 1'b0; m_ready = 1'b0; d2_s_valid = 1'b0; d2_m_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
      checks++; if (s_credit !== 4'b0000) begin errors++; $display("FAIL reset_credit: got %b want 0000", s_credit); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (m_vc !== 2'd0) begin errors++; $display("FAIL reset_vc: got %0d want 0", m_vc); end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle(0, 0, '0, 1);
         checks++;
         if (s_credit !== ((c < 2) ? 4'b1111 : 4'b0000)) begin
            errors++; $display("FAIL burst_credit[%0d]: got %b want %b", c, s_credit, (c < 2) ? 4'b1111 : 4'b0000);
         end
         checks++; if (m_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL burst_idle[%0d]: got valid=%b err=%b want 0 0", c, m_valid, err);
         end
      end
   endtask

   task automatic test_single();
      cycle(1, 2, 8'hA5, 1);
      checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_vc !== 2'd2) begin
         errors++; $display("FAIL single_out: got v=%b d=%h vc=%0d want 1 a5 2", m_valid, m_data, m_vc);
      end
      checks++; if (s_credit !== 4'b0000) begin errors++; $display("FAIL single_nocredit: got %b want 0000", s_credit); end
      cycle(0, 0, '0, 1);
      checks++; if (s_credit !== 4'b0100) begin errors++; $display("FAIL single_credit: got %b want 0100", s_credit); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", m_valid); end
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 3, 0, 1, 3};
      int pulses [VN];
      for (int v = 0; v < VN; v++) pulses[v] = 0;
      for (int k = 0; k < 6; k++) cycle(1, order[k], DW'($urandom), 0);
      for (int k = 0; k < 6; k++) begin
         checks++; if (m_valid !== 1'b1 || m_vc !== VW'(order[k])) begin
            errors++; $display("FAIL rr_order[%0d]: got v=%b vc=%0d want 1 %0d", k, m_valid, m_vc, order[k]);
         end
         checks++; if (m_data !== mq[order[k]][0]) begin
            errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, m_data, mq[order[k]][0]);
         end
         cycle(0, 0, '0, 1);
         for (int v = 0; v < VN; v++) pulses[v] += int'(s_credit[v]);
      end
      for (int k = 0; k < 2; k++) begin
         cycle(0, 0, '0, 1);
         for (int v = 0; v < VN; v++) pulses[v] += int'(s_credit[v]);
      end
      for (int v = 0; v < VN; v++) begin
         checks++; if (pulses[v] !== ((v == 2) ? 0 : 2)) begin
            errors++; $display("FAIL rr_pulses[%0d]: got %0d want %0d", v, pulses[v], (v == 2) ? 0 : 2);
         end
      end
   endtask

   task automatic test_stall();
      cycle(1, 1, 8'h11, 0);
      checks++; if (m_valid !== 1'b1 || m_vc !== 2'd1) begin errors++; $display("FAIL stall_first: got v=%b vc=%0d want 1 1", m_valid, m_vc); end
      cycle(1, 0, 8'h22, 0);
      cycle(1, 3, 8'h33, 0);
      cycle(0, 0, '0, 0);
      checks++; if (m_vc !== 2'd1 || m_data !== 8'h11) begin errors++; $display("FAIL stall_hold: got vc=%0d d=%h want 1 11", m_vc, m_data); end
      cycle(0, 0, '0, 1);
      checks++; if (m_valid !== 1'b1 || m_vc !== 2'd3 || m_data !== 8'h33) begin
         errors++; $display("FAIL stall_next: got v=%b vc=%0d d=%h want 1 3 33", m_valid, m_vc, m_data);
      end
      cycle(0, 0, '0, 1);
      checks++; if (m_vc !== 2'd0 || m_data !== 8'h22) begin errors++; $display("FAIL stall_wrap: got vc=%0d d=%h want 0 22", m_vc, m_data); end
      cycle(0, 0, '0, 1);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b want 0", m_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      repeat (3) cycle(0, 0, '0, 0);
      cycle(1, 0, 8'h01, 0);
      cycle(1, 0, 8'h02, 0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", err); end
      cycle(1, 0, 8'h03, 0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err); end
      cycle(0, 0, '0, 1);
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h02) begin errors++; $display("FAIL ovf_second: got v=%b d=%h want 1 02", m_valid, m_data); end
      cycle(0, 0, '0, 1);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got %b want 0", m_valid); end
      repeat (3) cycle(0, 0, '0, 1);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", err); end
   endtask

   task automatic test_illegal_vc();
      do_reset();
      checks++; if (d2_err !== 1'b0) begin errors++; $display("FAIL ill_reset: got %b want 0", d2_err); end
      d2_s_valid = 1'b1; d2_s_vc = 3'd7; d2_s_data = 8'h3C; d2_m_ready = 1'b0;
      cycle(0, 0, '0, 0);
      d2_s_valid = 1'b0;
      checks++; if (d2_err !== 1'b1 || d2_m_valid !== 1'b0) begin
         errors++; $display("FAIL ill_drop: got err=%b v=%b want 1 0", d2_err, d2_m_valid);
      end
      d2_s_valid = 1'b1; d2_s_vc = 3'd4; d2_s_data = 8'h5A;
      cycle(0, 0, '0, 0);
      d2_s_valid = 1'b0;
      checks++; if (d2_m_valid !== 1'b1 || d2_m_vc !== 3'd4 || d2_m_data !== 8'h5A) begin
         errors++; $display("FAIL ill_top_vc: got v=%b vc=%0d d=%h want 1 4 5a", d2_m_valid, d2_m_vc, d2_m_data);
      end
      d2_m_ready = 1'b1;
      cycle(0, 0, '0, 0);
      checks++; if (d2_m_valid !== 1'b0 || d2_err !== 1'b1) begin
         errors++; $display("FAIL ill_drain: got v=%b err=%b want 0 1", d2_m_valid, d2_err);
      end
   endtask

   task automatic test_burst_pop();
      logic [4:0] seq0;
      int         n1;
      do_reset();
      seq0 = '0; n1 = 0;
      for (int c = 0; c < 5; c++) begin
         cycle(c == 1, 0, 8'h77, 1);
         seq0 = {seq0[3:0], s_credit[0]};
         n1 += int'(s_credit[1]);
         if (c == 1) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 8'h77) begin
               errors++; $display("FAIL burst_pop_out: got v=%b d=%h want 1 77", m_valid, m_data);
            end
         end
      end
      checks++; if (seq0 !== 5'b11100) begin errors++; $display("FAIL burst_pop_vc0: got %b want 11100", seq0); end
      checks++; if (n1 !== 2) begin errors++; $display("FAIL burst_pop_vc1: got %0d want 2", n1); end
   endtask

   task automatic test_random();
      int scred [VN];
      int vc, g;
      bit pv, rdy;
      do_reset();
      for (int v = 0; v < VN; v++) scred[v] = 0;
      for (int n = 0; n < 400; n++) begin
         vc  = int'($urandom_range(0, VN - 1));
         pv  = (scred[vc] > 0) && ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 9) < 7);
         if (pv) scred[vc]--;
         cycle(pv, vc, DW'($urandom), rdy);
         for (int v = 0; v < VN; v++) scred[v] += int'(mcred[v]);
         g = exp_grant();
         checks++; if (s_credit !== mcred) begin errors++; $display("FAIL rnd_credit[%0d]: got %b want %b", n, s_credit, mcred); end
         checks++; if (m_valid !== (g >= 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, m_valid, g >= 0); end
         if (g >= 0) begin
            checks++; if (m_vc !== VW'(g) || m_data !== mq[g][0]) begin
               errors++; $display("FAIL rnd_out[%0d]: got vc=%0d d=%h want %0d %h", n, m_vc, m_data, g, mq[g][0]);
            end
         end
         checks++; if (err !== merr) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err, merr); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      s_valid = 1'b0; s_vc = '0; s_data = '0; m_ready = 1'b0;
      d2_s_valid = 1'b0; d2_s_vc = '0; d2_s_data = '0; d2_m_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_overflow();
      test_illegal_vc();
      test_burst_pop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vc_vr_multi_converter.md
# vc_vr_multi_converter

Multi-virtual-channel valid/credit to valid/ready converter. Accepts flits on one valid/credit link carrying a VC id, buffers each VC in its own CREDIT_NUM-deep FIFO, returns credits per VC, and merges all VCs onto one valid/ready output through a stall-safe round-robin arbiter. Sits at the receive side of an interconnect link, in front of valid/ready consumers that must see per-VC fairness.

## Interface
- DATA_WIDTH, 8, flit payload width
- CREDIT_NUM, 2, per-VC buffer depth and initial credit count (>=1)
- VC_NUM, 2, number of virtual channels (>=1); VC_W = max(1, $clog2(VC_NUM))
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data_i  in  DATA_WIDTH  incoming flit
- s_vc_i  in  VC_W  VC of incoming flit
- s_valid_i  in  1  flit present this cycle (no ready; credit-governed)
- s_credit_o  out  VC_NUM  bit v = one credit returned for VC v this cycle
- m_data_o  out  DATA_WIDTH  outgoing flit
- m_vc_o  out  VC_W  VC of outgoing flit
- m_valid_o  out  1  outgoing flit valid
- m_ready_i  in  1  consumer ready
- err_o  out  1  sticky protocol error (overflow or illegal VC)

## Operation
- Push: s_valid_i && s_vc_i < VC_NUM && FIFO[s_vc_i] not full -> write. Full FIFO push dropped even if same VC pops that cycle; s_vc_i >= VC_NUM dropped. Either drop sets err_o (cleared only by reset).
- No bypass: pushed flit visible at FIFO head the following cycle.
- Credit counter pend[v], width $clog2(CREDIT_NUM+1), reset CREDIT_NUM. Each cycle avail = pend[v] + pop[v]; if avail > 0: s_credit_o[v] <= 1, pend[v] <= avail-1; else s_credit_o[v] <= 0, pend[v] <= 0. s_credit_o registered; at most one credit per VC per cycle; sum of pend, in-flight and stored never exceeds CREDIT_NUM for a compliant sender.
- Arbiter states: FREE, LOCKED.
  - FREE: grant = first non-empty VC scanning from rr_ptr upward with wrap (VC_NUM-1 -> 0). m_valid_o = any VC non-empty.
  - FREE and m_valid_o && !m_ready_i -> LOCKED, latch grant.
  - LOCKED: grant = latched VC; newly non-empty higher-priority VCs ignored. m_ready_i -> FREE on handshake.
- Handshake (m_valid_o && m_ready_i): pop FIFO[grant], rr_ptr <= grant+1 (wrap to 0 past VC_NUM-1).
- m_data_o/m_vc_o = head of FIFO[grant]/grant; held stable while m_valid_o && !m_ready_i.
- VC_NUM=1: degenerates to single FIFO, m_vc_o = 0.

## Timing
- Reset (async assert): s_credit_o = 0, m_valid_o = 0, err_o = 0, FIFOs empty, pend = CREDIT_NUM, rr_ptr = 0, state FREE. m_data_o don't-care while m_valid_o = 0; m_vc_o = 0.
- After deassert, first edge: s_credit_o = all ones; continues for CREDIT_NUM consecutive cycles per VC, then 0 unless pops occur.
- Push at edge t -> m_valid_o high from t+1 (min latency 1 cycle) if arbiter selects that VC.
- Handshake at edge t -> s_credit_o[v] high during cycle after t (1-cycle return); pop during initial credit burst extends the burst by one cycle.
- Back-to-back: one flit per cycle throughput on output with m_ready_i held high.
- Reset mid-operation: all stored flits and owed credits discarded, initial burst repeated.

## Test plan
- Reset, CREDIT_NUM=2, VC_NUM=4: release rst_n -> s_credit_o = 4'b1111 for exactly 2 cycles, then 0; m_valid_o, err_o = 0.
- Push 0xA5 on VC2, m_ready_i=1 -> next cycle m_valid_o=1, m_data_o=0xA5, m_vc_o=2; cycle after handshake s_credit_o=4'b0100.
- Fill VC0,1,3 with 2 flits each, m_ready_i=1 -> output VC order 0,1,3,0,1,3, one per cycle; each VC gets 2 credit pulses.
- m_ready_i=0 with VC1 pending, then push VC0 -> m_vc_o stays 1 and data stable until ready; after handshake next grant is VC3 if non-empty else VC0.
- Third push to VC0 without pop (CREDIT_NUM=2) -> flit dropped, err_o=1 stays set; push with s_vc_i=5 (VC_NUM=4, VC_W=2 -> use VC_NUM=5 bench, s_vc_i=7) -> dropped, err_o=1.
- Pop VC0 during initial credit burst (push in cycle 1, ready high) -> VC0 credit pulses total 3, contiguous, no pulse lost.
